// File: rtl/load_extend_queue.sv
// Load-data formatter: byte-lane select with zero/sign extension or word
// pass-through, buffered in a small first-word-fall-through queue.
module load_extend_queue #(
  parameter  int WORD_W = 16,
  parameter  int DEPTH  = 2,
  localparam int LANE_W = $clog2(WORD_W/8),
  localparam int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic [LANE_W-1:0] in_lane,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_err,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic              err;
    logic [WORD_W-1:0] data;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       lane_byte;
  entry_t           fmt;
  logic             push, pop;

  assign lane_byte = in_data[{in_lane, 3'b000} +: 8];

  always_comb begin
    fmt = '0;
    case (in_mode)
      2'b00:   fmt.data = {{(WORD_W-8){1'b0}}, lane_byte};
      2'b01:   fmt.data = {{(WORD_W-8){lane_byte[7]}}, lane_byte};
      2'b10:   fmt.data = in_data;
      default: fmt.err  = 1'b1;
    endcase
  end

  // Ready comes from registered count only; a full queue never
  // accepts, even when the head is popped in the same cycle.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= fmt;
  end

  assign out_data = out_valid ? mem_q[rd_ptr_q].data : '0;
  assign out_err  = out_valid ? mem_q[rd_ptr_q].err  : 1'b0;
  assign count    = count_q;

endmodule

// File: tb/tb_load_extend_queue.sv
// Directed bench for load_extend_queue: a 16-bit/2-deep instance and a
// 32-bit/4-deep instance, driven and sampled on the falling clock edge.
module tb_load_extend_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int chk = 0;
  int err = 0;

  // 16-bit, 2-deep instance
  logic        ra, a_iv, a_ir, a_ov, a_or, a_oe, a_ln;
  logic [15:0] a_id, a_od;
  logic [1:0]  a_md, a_cnt;

  load_extend_queue #(.WORD_W(16), .DEPTH(2)) u_a (
    .clk(clk), .reset(ra),
    .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .in_lane(a_ln), .in_mode(a_md),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
    .out_err(a_oe), .count(a_cnt)
  );

  // 32-bit, 4-deep instance
  logic        rb, b_iv, b_ir, b_ov, b_or, b_oe;
  logic [31:0] b_id, b_od;
  logic [1:0]  b_ln, b_md;
  logic [2:0]  b_cnt;

  load_extend_queue #(.WORD_W(32), .DEPTH(4)) u_b (
    .clk(clk), .reset(rb),
    .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .in_lane(b_ln), .in_mode(b_md),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
    .out_err(b_oe), .count(b_cnt)
  );

  task automatic a_push(input logic [15:0] d, input logic l,
                        input logic [1:0] m);
    a_iv = 1'b1; a_id = d; a_ln = l; a_md = m;
    @(negedge clk);
    a_iv = 1'b0;
  endtask

  task automatic b_push(input logic [31:0] d, input logic [1:0] l,
                        input logic [1:0] m);
    b_iv = 1'b1; b_id = d; b_ln = l; b_md = m;
    @(negedge clk);
    b_iv = 1'b0;
  endtask

  task automatic test_reset;
    ra = 1'b1; rb = 1'b1;
    a_iv = 0; a_or = 0; a_id = '0; a_ln = 0; a_md = '0;
    b_iv = 0; b_or = 0; b_id = '0; b_ln = '0; b_md = '0;
    repeat (2) @(negedge clk);
    ra = 1'b0; rb = 1'b0;
    chk++;
    if (a_ov !== 1'b0 || a_ir !== 1'b1 || a_cnt !== 2'd0) begin
      err++;
      $display("FAIL reset_ctl got ov=%b ir=%b cnt=%0d exp 0 1 0",
               a_ov, a_ir, a_cnt);
    end
    chk++;
    if (a_od !== 16'h0000 || a_oe !== 1'b0) begin
      err++;
      $display("FAIL reset_out got %h/%b exp 0000/0", a_od, a_oe);
    end
  endtask

  task automatic test_zero_ext;
    a_or = 1'b1;
    a_push(16'hF0FF, 1'b0, 2'b00);
    chk++;
    if (a_ov !== 1'b1 || a_od !== 16'h00FF || a_oe !== 1'b0 ||
        a_cnt !== 2'd1) begin
      err++;
      $display("FAIL zext got ov=%b d=%h e=%b c=%0d exp 1 00ff 0 1",
               a_ov, a_od, a_oe, a_cnt);
    end
    @(negedge clk);
    a_or = 1'b0;
    chk++;
    if (a_cnt !== 2'd0 || a_ov !== 1'b0) begin
      err++;
      $display("FAIL zext_pop got c=%0d ov=%b exp 0 0", a_cnt, a_ov);
    end
  endtask

  task automatic test_sign_ext;
    logic [15:0] vd [4] = '{16'hF0FF, 16'h0021, 16'h0098, 16'h0098};
    logic        vl [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0]  vm [4] = '{2'b01, 2'b01, 2'b01, 2'b00};
    logic [15:0] ve [4] = '{16'hFFF0, 16'h0021, 16'hFF98, 16'h0098};
    for (int i = 0; i < 4; i++) begin
      a_or = 1'b0;
      a_push(vd[i], vl[i], vm[i]);
      chk++;
      if (a_od !== ve[i] || a_oe !== 1'b0) begin
        err++;
        $display("FAIL fmt[%0d] got %h/%b exp %h/0",
                 i, a_od, a_oe, ve[i]);
      end
      a_or = 1'b1;
      @(negedge clk);
      a_or = 1'b0;
      chk++;
      if (a_cnt !== 2'd0) begin
        err++;
        $display("FAIL fmt_pop[%0d] got c=%0d exp 0", i, a_cnt);
      end
    end
  endtask

  task automatic test_full;
    a_or = 1'b0;
    a_push(16'h1234, 1'b0, 2'b10);
    a_push(16'hABCD, 1'b1, 2'b11);
    chk++;
    if (a_ir !== 1'b0 || a_cnt !== 2'd2 || a_od !== 16'h1234 ||
        a_oe !== 1'b0) begin
      err++;
      $display("FAIL full got ir=%b c=%0d d=%h e=%b exp 0 2 1234 0",
               a_ir, a_cnt, a_od, a_oe);
    end
    @(negedge clk);
    chk++;
    if (a_od !== 16'h1234 || a_cnt !== 2'd2) begin
      err++;
      $display("FAIL stall_hold got d=%h c=%0d exp 1234 2", a_od, a_cnt);
    end
    a_or = 1'b1;
    a_push(16'h5555, 1'b0, 2'b00);
    a_or = 1'b0;
    chk++;
    if (a_cnt !== 2'd1 || a_ov !== 1'b1 || a_od !== 16'h0000 ||
        a_oe !== 1'b1) begin
      err++;
      $display("FAIL full_pop got c=%0d ov=%b d=%h e=%b exp 1 1 0000 1",
               a_cnt, a_ov, a_od, a_oe);
    end
    a_or = 1'b1;
    @(negedge clk);
    a_or = 1'b0;
    chk++;
    if (a_cnt !== 2'd0 || a_ov !== 1'b0) begin
      err++;
      $display("FAIL full_drop got c=%0d ov=%b exp 0 0", a_cnt, a_ov);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] w;
    a_or = 1'b1;
    a_iv = 1'b1; a_ln = 1'b0; a_md = 2'b00;
    for (int i = 1; i <= 9; i++) begin
      w = 16'(i);
      a_id = w;
      @(negedge clk);
      chk++;
      if (a_od !== w || a_cnt !== 2'd1 || a_ov !== 1'b1) begin
        err++;
        $display("FAIL b2b[%0d] got d=%h c=%0d ov=%b exp %h 1 1",
                 i, a_od, a_cnt, a_ov, w);
      end
    end
    a_iv = 1'b0;
    @(negedge clk);
    a_or = 1'b0;
    chk++;
    if (a_cnt !== 2'd0 || a_ov !== 1'b0) begin
      err++;
      $display("FAIL b2b_drain got c=%0d ov=%b exp 0 0", a_cnt, a_ov);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    a_or = 1'b0;
    a_push(16'h0011, 1'b0, 2'b10);
    a_push(16'h0022, 1'b0, 2'b10);
    chk++;
    if (a_cnt !== 2'd2) begin
      err++;
      $display("FAIL rst_fill got c=%0d exp 2", a_cnt);
    end
    a_or = 1'b1;
    @(negedge clk);
    a_or = 1'b0;
    ra = 1'b1;
    a_push(16'h0033, 1'b0, 2'b10);
    ra = 1'b0;
    chk++;
    if (a_cnt !== 2'd0 || a_ov !== 1'b0 || a_od !== 16'h0000 ||
        a_ir !== 1'b1) begin
      err++;
      $display("FAIL rst_mid got c=%0d ov=%b d=%h ir=%b exp 0 0 0000 1",
               a_cnt, a_ov, a_od, a_ir);
    end
    seen = 0;
    a_or = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (a_ov !== 1'b0) seen++;
    end
    a_or = 1'b0;
    chk++;
    if (seen != 0) begin
      err++;
      $display("FAIL rst_ghost got %0d valid cycles exp 0", seen);
    end
  endtask

  task automatic test_wide;
    logic [1:0]  vl [3] = '{2'd2, 2'd1, 2'd3};
    logic [1:0]  vm [3] = '{2'b01, 2'b01, 2'b00};
    logic [31:0] ve [3] = '{32'hFFFFFFFF, 32'h0000007F, 32'h00000080};
    for (int i = 0; i < 3; i++) begin
      b_or = 1'b0;
      b_push(32'h80FF7F01, vl[i], vm[i]);
      chk++;
      if (b_od !== ve[i] || b_oe !== 1'b0 || b_cnt !== 3'd1) begin
        err++;
        $display("FAIL wide[%0d] got %h/%b c=%0d exp %h/0 1",
                 i, b_od, b_oe, b_cnt, ve[i]);
      end
      b_or = 1'b1;
      @(negedge clk);
      b_or = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      chk++;
      if (b_ir !== 1'b1) begin
        err++;
        $display("FAIL wide_ir[%0d] got %b exp 1", i, b_ir);
      end
      b_push(32'h11111111 * 32'(i + 1), 2'd0, 2'b10);
    end
    chk++;
    if (b_ir !== 1'b0 || b_cnt !== 3'd4 || b_od !== 32'h11111111) begin
      err++;
      $display("FAIL wide_full got ir=%b c=%0d d=%h exp 0 4 11111111",
               b_ir, b_cnt, b_od);
    end
    for (int i = 0; i < 4; i++) begin
      chk++;
      if (b_od !== 32'h11111111 * 32'(i + 1)) begin
        err++;
        $display("FAIL wide_order[%0d] got %h exp %h",
                 i, b_od, 32'h11111111 * 32'(i + 1));
      end
      b_or = 1'b1;
      @(negedge clk);
      b_or = 1'b0;
    end
    chk++;
    if (b_cnt !== 3'd0 || b_ov !== 1'b0) begin
      err++;
      $display("FAIL wide_drain got c=%0d ov=%b exp 0 0", b_cnt, b_ov);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_zero_ext;
    test_sign_ext;
    test_full;
    test_back_to_back;
    test_reset_mid;
    test_wide;
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
